// File: rtl/cache_noc_interface_pkg.sv
// rtl/cache_noc_interface_pkg.sv - message codes, coherence states and snoop FSM type
package cache_noc_interface_pkg;

    localparam logic [3:0] NO_MSG    = 4'd0;
    localparam logic [3:0] NO_REQ    = 4'd0;
    localparam logic [3:0] GETS      = 4'd1;
    localparam logic [3:0] R_REQ     = 4'd1;
    localparam logic [3:0] GETM      = 4'd2;
    localparam logic [3:0] W_REQ     = 4'd2;
    localparam logic [3:0] PUTM      = 4'd3;
    localparam logic [3:0] WB_REQ    = 4'd3;
    localparam logic [3:0] FLUSH_REQ = 4'd4;
    localparam logic [3:0] PUTE      = 4'd5;
    localparam logic [3:0] INV       = 4'd6;
    localparam logic [3:0] FWD_GETS  = 4'd7;
    localparam logic [3:0] FWD_GETM  = 4'd8;
    localparam logic [3:0] DATA_S    = 4'd9;
    localparam logic [3:0] DATA_E    = 4'd10;
    localparam logic [3:0] DATA_M    = 4'd11;
    localparam logic [3:0] INV_ACK   = 4'd12;
    localparam logic [3:0] PUT_ACK   = 4'd13;
    localparam logic [3:0] RESP_PUTM = 4'd14;

    localparam logic [3:0] MEM_RESP   = 4'd1;
    localparam logic [3:0] MEM_RESP_S = 4'd2;
    localparam logic [3:0] MEM_RESP_E = 4'd3;

    localparam logic [1:0] INVALID   = 2'b00;
    localparam logic [1:0] EXCLUSIVE = 2'b01;
    localparam logic [1:0] MODIFIED  = 2'b10;
    localparam logic [1:0] SHARED    = 2'b11;

    typedef enum logic [2:0] {
        SNP_IDLE,
        SNP_READ,
        SNP_WAIT,
        SNP_ACT,
        SNP_SEND
    } snoop_state_t;

    function automatic logic is_fwd_msg(input logic [3:0] m);
        return (m == INV) || (m == FWD_GETS) || (m == FWD_GETM);
    endfunction

    function automatic logic is_resp_msg(input logic [3:0] m);
        return (m == DATA_S) || (m == DATA_E) || (m == DATA_M) ||
               (m == PUT_ACK) || (m == INV_ACK);
    endfunction

    function automatic logic [3:0] ctl_to_noc(input logic [3:0] m);
        case (m)
            R_REQ:   return GETS;
            W_REQ:   return GETM;
            default: return PUTM;
        endcase
    endfunction

    function automatic logic [3:0] resp_code(input logic [3:0] m);
        case (m)
            DATA_S:  return MEM_RESP_S;
            DATA_E:  return MEM_RESP_E;
            default: return MEM_RESP;
        endcase
    endfunction

endpackage

// File: rtl/cache_noc_interface_fifo.sv
// rtl/cache_noc_interface_fifo.sv - small synchronous FIFO, push into a full FIFO accepted only with a pop
module cache_noc_interface_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (DEPTH_BITS+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cache_noc_interface.sv
// rtl/cache_noc_interface.sv - L1 coherence adapter: controller requests to NoC, directory snoops via port1
module cache_noc_interface
    import cache_noc_interface_pkg::*;
#(
    parameter int    STATUS_BITS         = 2,
    parameter int    COHERENCE_BITS      = 2,
    parameter int    CACHE_OFFSET_BITS   = 2,
    parameter int    DATA_WIDTH          = 32,
    parameter int    NUMBER_OF_WAYS      = 4,
    parameter int    ADDRESS_BITS        = 32,
    parameter int    INDEX_BITS          = 8,
    parameter int    MSG_BITS            = 4,
    parameter int    MAX_OFFSET_BITS     = 3,
    parameter int    REQ_BUF_DEPTH_BITS  = 2,
    parameter int    RESP_BUF_DEPTH_BITS = 2,
    parameter int    CORE                = 0,
    parameter int    CACHE_NO            = 0,
    parameter string CONTROLLER_TYPE     = "BLOCKING",
    parameter int    ID_BITS             = 2,
    parameter int    DEFAULT_DEST        = 0,
    localparam int   CACHE_WORDS         = 1 << CACHE_OFFSET_BITS,
    localparam int   CACHE_WIDTH         = DATA_WIDTH * CACHE_WORDS,
    localparam int   WAY_BITS            = (NUMBER_OF_WAYS > 1) ? $clog2(NUMBER_OF_WAYS) : 1,
    localparam int   TAG_BITS            = ADDRESS_BITS - INDEX_BITS - CACHE_OFFSET_BITS,
    localparam int   SBITS               = COHERENCE_BITS + STATUS_BITS
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [MSG_BITS-1:0]       noc_msg_in,
    input  logic [ADDRESS_BITS-1:0]   noc_address_in,
    input  logic [CACHE_WIDTH-1:0]    noc_data_in,
    input  logic [ID_BITS-1:0]        noc_src_id,
    input  logic                      packetizer_busy,
    output logic [MSG_BITS-1:0]       noc_msg_out,
    output logic [ADDRESS_BITS-1:0]   noc_address_out,
    output logic [CACHE_WIDTH-1:0]    noc_data_out,
    output logic [ID_BITS-1:0]        noc_dest_id,
    input  logic [MSG_BITS-1:0]       cache_msg_in,
    input  logic [ADDRESS_BITS-1:0]   cache_address_in,
    input  logic [CACHE_WIDTH-1:0]    cache_data_in,
    output logic [MSG_BITS-1:0]       cache_msg_out,
    output logic [ADDRESS_BITS-1:0]   cache_address_out,
    output logic [CACHE_WIDTH-1:0]    cache_data_out,
    output logic                      busy,
    input  logic [CACHE_WIDTH-1:0]    port1_read_data,
    input  logic [WAY_BITS-1:0]       port1_matched_way,
    input  logic [COHERENCE_BITS-1:0] port1_coh_bits,
    input  logic [STATUS_BITS-1:0]    port1_status_bits,
    input  logic                      port1_hit,
    output logic                      port1_read,
    output logic                      port1_write,
    output logic                      port1_invalidate,
    output logic [INDEX_BITS-1:0]     port1_index,
    output logic [TAG_BITS-1:0]       port1_tag,
    output logic [SBITS-1:0]          port1_metadata,
    output logic [CACHE_WIDTH-1:0]    port1_write_data,
    output logic [WAY_BITS-1:0]       port1_way_select
);
    localparam int REQ_W  = ID_BITS + MSG_BITS + ADDRESS_BITS;
    localparam int RESP_W = MSG_BITS + ADDRESS_BITS + CACHE_WIDTH;

    logic                    req_empty, req_full, resp_empty, resp_full, resp_pop;
    logic [REQ_W-1:0]        req_head;
    logic [RESP_W-1:0]       resp_head;
    logic [ID_BITS-1:0]      req_head_src;
    logic [MSG_BITS-1:0]     req_head_msg, resp_head_msg;
    logic [ADDRESS_BITS-1:0] req_head_addr, resp_head_addr;
    logic [CACHE_WIDTH-1:0]  resp_head_data;

    snoop_state_t state, next_state;
    logic                      send_snoop;
    logic [ID_BITS-1:0]        snp_src;
    logic [MSG_BITS-1:0]       snp_msg;
    logic [ADDRESS_BITS-1:0]   snp_addr;
    logic                      snp_hit;
    logic [WAY_BITS-1:0]       snp_way;
    logic [COHERENCE_BITS-1:0] snp_coh;
    logic [STATUS_BITS-1:0]    snp_status;
    logic [CACHE_WIDTH-1:0]    snp_data;
    logic                      act_inv, act_write;
    logic [SBITS-1:0]          new_meta;
    logic [MSG_BITS-1:0]       reply_msg;
    logic [CACHE_WIDTH-1:0]    reply_data;

    logic                      outstanding, ctl_pending;
    logic [MSG_BITS-1:0]       ctl_msg;
    logic [ADDRESS_BITS-1:0]   ctl_addr;
    logic [CACHE_WIDTH-1:0]    ctl_data;

    assign {req_head_src, req_head_msg, req_head_addr}     = req_head;
    assign {resp_head_msg, resp_head_addr, resp_head_data} = resp_head;
    assign busy = req_full || resp_full;

    cache_noc_interface_fifo #(.WIDTH(REQ_W), .DEPTH_BITS(REQ_BUF_DEPTH_BITS)) req_fifo (
        .clock(clock), .reset(reset),
        .push(is_fwd_msg(noc_msg_in)), .push_data({noc_src_id, noc_msg_in, noc_address_in}),
        .pop(state == SNP_READ), .pop_data(req_head), .empty(req_empty), .full(req_full)
    );

    cache_noc_interface_fifo #(.WIDTH(RESP_W), .DEPTH_BITS(RESP_BUF_DEPTH_BITS)) resp_fifo (
        .clock(clock), .reset(reset),
        .push(is_resp_msg(noc_msg_in)), .push_data({noc_msg_in, noc_address_in, noc_data_in}),
        .pop(resp_pop), .pop_data(resp_head), .empty(resp_empty), .full(resp_full)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= SNP_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            SNP_IDLE: if (!req_empty) next_state = SNP_READ;
            SNP_READ: next_state = SNP_WAIT;
            SNP_WAIT: next_state = SNP_ACT;
            SNP_ACT:  next_state = SNP_SEND;
            SNP_SEND: if (!packetizer_busy) next_state = req_empty ? SNP_IDLE : SNP_READ;
            default:  next_state = SNP_IDLE;
        endcase
    end

    always_comb begin
        port1_read       = 1'b0;
        port1_write      = 1'b0;
        port1_invalidate = 1'b0;
        port1_index      = '0;
        port1_tag        = '0;
        port1_metadata   = '0;
        port1_write_data = '0;
        port1_way_select = '0;
        send_snoop       = 1'b0;
        case (state)
            SNP_READ: begin
                port1_read  = 1'b1;
                port1_index = req_head_addr[CACHE_OFFSET_BITS +: INDEX_BITS];
                port1_tag   = req_head_addr[ADDRESS_BITS-1 -: TAG_BITS];
            end
            SNP_ACT: if (act_inv || act_write) begin
                port1_index      = snp_addr[CACHE_OFFSET_BITS +: INDEX_BITS];
                port1_tag        = snp_addr[ADDRESS_BITS-1 -: TAG_BITS];
                port1_way_select = snp_way;
                port1_invalidate = act_inv;
                port1_write      = act_write;
                if (act_write) begin
                    port1_metadata   = new_meta;
                    port1_write_data = snp_data;
                end
            end
            SNP_SEND: send_snoop = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snp_src <= '0; snp_msg <= '0; snp_addr <= '0;
            snp_hit <= 1'b0; snp_way <= '0; snp_coh <= '0; snp_status <= '0; snp_data <= '0;
        end else if (state == SNP_READ) begin
            snp_src <= req_head_src; snp_msg <= req_head_msg; snp_addr <= req_head_addr;
        end else if (state == SNP_WAIT) begin
            snp_hit <= port1_hit; snp_way <= port1_matched_way; snp_coh <= port1_coh_bits;
            snp_status <= port1_status_bits; snp_data <= port1_read_data;
        end
    end

    // A hit on an INVALID line is treated like a miss; FwdGetM follows the Inv path.
    always_comb begin
        act_inv    = 1'b0;
        act_write  = 1'b0;
        new_meta   = '0;
        reply_msg  = INV_ACK;
        reply_data = '0;
        if (snp_hit && snp_coh != INVALID) begin
            if (snp_msg == FWD_GETS) begin
                if (snp_coh == EXCLUSIVE) begin
                    act_write = 1'b1;
                    new_meta  = {snp_status, SHARED};
                    reply_msg = PUTE;
                end else if (snp_coh == MODIFIED) begin
                    act_write  = 1'b1;
                    new_meta   = {STATUS_BITS'(2'b10), SHARED};
                    reply_msg  = RESP_PUTM;
                    reply_data = snp_data;
                end
            end else begin
                act_inv = 1'b1;
                if (snp_coh == MODIFIED) begin
                    reply_msg  = RESP_PUTM;
                    reply_data = snp_data;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outstanding <= 1'b0; ctl_pending <= 1'b0;
            ctl_msg <= '0; ctl_addr <= '0; ctl_data <= '0;
        end else begin
            if (ctl_pending && !send_snoop && !packetizer_busy) ctl_pending <= 1'b0;
            if (cache_msg_in == NO_REQ) begin
                outstanding <= 1'b0;
            end else if (!outstanding && cache_msg_in <= FLUSH_REQ) begin
                outstanding <= 1'b1;
                ctl_pending <= 1'b1;
                ctl_msg     <= ctl_to_noc(cache_msg_in);
                ctl_addr    <= cache_address_in;
                ctl_data    <= (cache_msg_in == WB_REQ || cache_msg_in == FLUSH_REQ) ? cache_data_in : '0;
            end
        end
    end

    always_comb begin
        noc_msg_out     = NO_MSG;
        noc_address_out = '0;
        noc_data_out    = '0;
        noc_dest_id     = '0;
        if (send_snoop) begin
            noc_msg_out     = reply_msg;
            noc_address_out = snp_addr;
            noc_data_out    = reply_data;
            noc_dest_id     = snp_src;
        end else if (ctl_pending) begin
            noc_msg_out     = ctl_msg;
            noc_address_out = ctl_addr;
            noc_data_out    = ctl_data;
            noc_dest_id     = ID_BITS'(DEFAULT_DEST);
        end
    end

    // A shown response stays until the controller drops its request.
    assign resp_pop = !resp_empty && (cache_msg_out == NO_REQ || cache_msg_in == NO_REQ);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cache_msg_out <= '0; cache_address_out <= '0; cache_data_out <= '0;
        end else if (resp_pop) begin
            cache_msg_out     <= resp_code(resp_head_msg);
            cache_address_out <= resp_head_addr;
            cache_data_out    <= resp_head_data;
        end else if (cache_msg_in == NO_REQ) begin
            cache_msg_out <= '0; cache_address_out <= '0; cache_data_out <= '0;
        end
    end

endmodule

// File: tb/tb_cache_noc_interface.sv
// tb/tb_cache_noc_interface.sv - directed self-checking bench for cache_noc_interface
module tb_cache_noc_interface;
    import cache_noc_interface_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   noc_msg_in;
    logic [31:0]  noc_address_in;
    logic [127:0] noc_data_in;
    logic [1:0]   noc_src_id;
    logic         packetizer_busy;
    logic [3:0]   noc_msg_out;
    logic [31:0]  noc_address_out;
    logic [127:0] noc_data_out;
    logic [1:0]   noc_dest_id;
    logic [3:0]   cache_msg_in;
    logic [31:0]  cache_address_in;
    logic [127:0] cache_data_in;
    logic [3:0]   cache_msg_out;
    logic [31:0]  cache_address_out;
    logic [127:0] cache_data_out;
    logic         busy;
    logic [127:0] port1_read_data;
    logic [1:0]   port1_matched_way;
    logic [1:0]   port1_coh_bits;
    logic [1:0]   port1_status_bits;
    logic         port1_hit;
    logic         port1_read, port1_write, port1_invalidate;
    logic [7:0]   port1_index;
    logic [21:0]  port1_tag;
    logic [3:0]   port1_metadata;
    logic [127:0] port1_write_data;
    logic [1:0]   port1_way_select;

    always #5 clock = ~clock;

    cache_noc_interface dut (
        .clock(clock), .reset(reset),
        .noc_msg_in(noc_msg_in), .noc_address_in(noc_address_in), .noc_data_in(noc_data_in),
        .noc_src_id(noc_src_id), .packetizer_busy(packetizer_busy),
        .noc_msg_out(noc_msg_out), .noc_address_out(noc_address_out), .noc_data_out(noc_data_out),
        .noc_dest_id(noc_dest_id),
        .cache_msg_in(cache_msg_in), .cache_address_in(cache_address_in), .cache_data_in(cache_data_in),
        .cache_msg_out(cache_msg_out), .cache_address_out(cache_address_out), .cache_data_out(cache_data_out),
        .busy(busy),
        .port1_read_data(port1_read_data), .port1_matched_way(port1_matched_way),
        .port1_coh_bits(port1_coh_bits), .port1_status_bits(port1_status_bits), .port1_hit(port1_hit),
        .port1_read(port1_read), .port1_write(port1_write), .port1_invalidate(port1_invalidate),
        .port1_index(port1_index), .port1_tag(port1_tag), .port1_metadata(port1_metadata),
        .port1_write_data(port1_write_data), .port1_way_select(port1_way_select)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Snoop memory model: one-cycle read latency on port1
    logic         cfg_hit;
    logic [1:0]   cfg_way, cfg_coh, cfg_status;
    logic [127:0] cfg_data;
    always @(posedge clock) begin
        if (port1_read) begin
            port1_hit <= cfg_hit; port1_matched_way <= cfg_way; port1_coh_bits <= cfg_coh;
            port1_status_bits <= cfg_status; port1_read_data <= cfg_data;
        end else begin
            port1_hit <= 1'b0; port1_matched_way <= '0; port1_coh_bits <= '0;
            port1_status_bits <= '0; port1_read_data <= '0;
        end
    end

    logic        mon_en = 1'b0;
    int          n_replies = 0;
    logic [31:0] exp_q[$];
    always @(negedge clock) begin
        if (mon_en && noc_msg_out != NO_MSG && !packetizer_busy) begin
            n_replies++;
            check("burst_msg", noc_msg_out, INV_ACK);
            check("burst_queue_nonempty", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) check("burst_addr", noc_address_out, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_noc(input logic [3:0] m, input logic [31:0] a, input logic [127:0] d, input logic [1:0] s);
        noc_msg_in = m; noc_address_in = a; noc_data_in = d; noc_src_id = s;
        step();
        noc_msg_in = NO_MSG; noc_address_in = '0; noc_data_in = '0; noc_src_id = '0;
    endtask

    task automatic wait_resp(input string nm);
        int k = 0;
        while (cache_msg_out == NO_REQ && k < 20) begin step(); k++; end
        check({nm, "_arrived"}, cache_msg_out != NO_REQ, 1'b1);
    endtask

    task automatic snoop_case(input string nm, input logic [3:0] m, input logic [31:0] a, input logic [1:0] src,
                              input logic hit, input logic [1:0] way, input logic [1:0] coh, input logic [1:0] st,
                              input logic [127:0] d, input logic [21:0] exp_tag, input logic exp_inv,
                              input logic exp_wr, input logic [1:0] exp_way, input logic [3:0] exp_meta,
                              input logic [3:0] exp_reply, input logic [127:0] exp_data);
        cfg_hit = hit; cfg_way = way; cfg_coh = coh; cfg_status = st; cfg_data = d;
        send_noc(m, a, '0, src);
        step();
        check({nm, "_read"}, port1_read, 1'b1);
        check({nm, "_tag"}, port1_tag, exp_tag);
        check({nm, "_index"}, port1_index, 8'h00);
        step();
        check({nm, "_wait_quiet"}, {port1_read, port1_invalidate, port1_write}, 3'b000);
        step();
        check({nm, "_inv"}, port1_invalidate, exp_inv);
        check({nm, "_write"}, port1_write, exp_wr);
        check({nm, "_way"}, port1_way_select, exp_way);
        check({nm, "_meta"}, port1_metadata, exp_meta);
        step();
        check({nm, "_reply"}, noc_msg_out, exp_reply);
        check({nm, "_reply_addr"}, noc_address_out, a);
        check({nm, "_reply_data"}, noc_data_out, exp_data);
        check({nm, "_reply_dest"}, noc_dest_id, src);
        check({nm, "_send_quiet"}, {port1_invalidate, port1_write}, 2'b00);
        step();
        check({nm, "_done"}, noc_msg_out, NO_MSG);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_busy;
        int   k;
        reset = 1'b1;
        noc_msg_in = '0; noc_address_in = '0; noc_data_in = '0; noc_src_id = '0;
        packetizer_busy = 1'b0;
        cache_msg_in = '0; cache_address_in = '0; cache_data_in = '0;
        cfg_hit = 1'b0; cfg_way = '0; cfg_coh = '0; cfg_status = '0; cfg_data = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        step();
        check("reset_noc_msg", noc_msg_out, NO_MSG);
        check("reset_cache_msg", cache_msg_out, NO_REQ);
        check("reset_busy", busy, 1'b0);
        check("reset_port1", {port1_read, port1_write, port1_invalidate}, 3'b000);

        // R_REQ -> GetS, DataS -> MEM_RESP_S
        cache_msg_in = R_REQ; cache_address_in = 32'h1000;
        step();
        check("rreq_msg", noc_msg_out, GETS);
        check("rreq_addr", noc_address_out, 32'h1000);
        check("rreq_dest", noc_dest_id, 2'd0);
        step();
        check("rreq_consumed", noc_msg_out, NO_MSG);
        send_noc(DATA_S, 32'h1000, {32'd1, 32'd2, 32'd3, 32'd4}, 2'd0);
        wait_resp("datas");
        check("datas_code", cache_msg_out, MEM_RESP_S);
        check("datas_addr", cache_address_out, 32'h1000);
        check("datas_data", cache_data_out, {32'd1, 32'd2, 32'd3, 32'd4});
        step();
        check("datas_held", cache_msg_out, MEM_RESP_S);
        check("rreq_not_resent", noc_msg_out, NO_MSG);
        cache_msg_in = NO_REQ;
        step();
        check("datas_cleared", cache_msg_out, NO_REQ);

        // W_REQ -> GetM, DataE -> MEM_RESP_E
        cache_msg_in = W_REQ; cache_address_in = 32'h1040;
        step();
        check("wreq_msg", noc_msg_out, GETM);
        check("wreq_data", noc_data_out, 128'h0);
        send_noc(DATA_E, 32'h1040, 128'h55, 2'd0);
        wait_resp("datae");
        check("datae_code", cache_msg_out, MEM_RESP_E);
        cache_msg_in = NO_REQ;
        step();
        check("datae_cleared", cache_msg_out, NO_REQ);

        // Snoop cases
        snoop_case("inv_m", INV, 32'h2000, 2'd1, 1'b1, 2'd3, MODIFIED, 2'b11,
                   128'h20000003_20000002_20000001_20000000, 22'h8, 1'b1, 1'b0, 2'd3, 4'h0,
                   RESP_PUTM, 128'h20000003_20000002_20000001_20000000);
        snoop_case("inv_s", INV, 32'h3000, 2'd2, 1'b1, 2'd2, SHARED, 2'b01,
                   128'hDEAD_BEEF, 22'hC, 1'b1, 1'b0, 2'd2, 4'h0, INV_ACK, 128'h0);
        snoop_case("fgs_e", FWD_GETS, 32'h4000, 2'd3, 1'b1, 2'd0, EXCLUSIVE, 2'b10,
                   128'h1234, 22'h10, 1'b0, 1'b1, 2'd0, 4'b1011, PUTE, 128'h0);
        snoop_case("inv_miss", INV, 32'h9000, 2'd1, 1'b0, 2'd1, INVALID, 2'b00,
                   128'h9999, 22'h24, 1'b0, 1'b0, 2'd0, 4'h0, INV_ACK, 128'h0);
        snoop_case("fgm_m", FWD_GETM, 32'h5000, 2'd2, 1'b1, 2'd1, MODIFIED, 2'b11,
                   128'hABCD_0001, 22'h14, 1'b1, 1'b0, 2'd1, 4'h0, RESP_PUTM, 128'hABCD_0001);
        snoop_case("fgs_m", FWD_GETS, 32'h6000, 2'd0, 1'b1, 2'd2, MODIFIED, 2'b11,
                   128'h6666_7777, 22'h18, 1'b0, 1'b1, 2'd2, 4'b1011, RESP_PUTM, 128'h6666_7777);

        // Burst of 9 forwarded requests, sender honors busy
        cfg_hit = 1'b0; cfg_coh = INVALID;
        saw_busy = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            k = 0;
            while (busy && k < 50) begin saw_busy = 1'b1; step(); k++; end
            check("burst_busy_wait", busy, 1'b0);
            exp_q.push_back(32'h10000 + 32'(i) * 32'h100);
            send_noc(INV, 32'h10000 + 32'(i) * 32'h100, '0, 2'(i));
        end
        k = 0;
        while (n_replies < 9 && k < 200) begin step(); k++; end
        check("burst_count", n_replies, 9);
        check("burst_busy_seen", saw_busy, 1'b1);
        check("burst_busy_clear", busy, 1'b0);
        mon_en = 1'b0;

        // WB_REQ held while packetizer is busy
        packetizer_busy = 1'b1;
        cache_msg_in = WB_REQ; cache_address_in = 32'h20000; cache_data_in = 128'hCAFE_F00D_0000_0001;
        step();
        check("wb_msg", noc_msg_out, PUTM);
        check("wb_addr", noc_address_out, 32'h20000);
        check("wb_data", noc_data_out, 128'hCAFE_F00D_0000_0001);
        check("wb_dest", noc_dest_id, 2'd0);
        repeat (3) step();
        check("wb_held_msg", noc_msg_out, PUTM);
        check("wb_held_addr", noc_address_out, 32'h20000);
        packetizer_busy = 1'b0;
        @(negedge clock);
        check("wb_before_edge", noc_msg_out, PUTM);
        step();
        check("wb_consumed", noc_msg_out, NO_MSG);
        send_noc(PUT_ACK, 32'h20000, '0, 2'd0);
        wait_resp("putack");
        check("putack_code", cache_msg_out, MEM_RESP);
        check("putack_addr", cache_address_out, 32'h20000);
        cache_msg_in = NO_REQ;
        step();
        check("putack_cleared", cache_msg_out, NO_REQ);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_noc_interface.md
# cache_noc_interface

Coherence-side adapter between one private L1 cache controller and the on-chip network (MESI directory protocol). It translates controller requests into NoC coherence requests and returns directory data and acks to the controller. It also services directory-forwarded requests (Inv, FwdGetS, FwdGetM) by snooping the cache memory through a dedicated second port (port1) and answering the directory.

## Interface
- STATUS_BITS, 2, valid/dirty status bits per line
- COHERENCE_BITS, 2, MESI state width
- CACHE_OFFSET_BITS, 2, word-offset bits (word addresses)
- DATA_WIDTH, 32, word width
- NUMBER_OF_WAYS, 4, associativity
- ADDRESS_BITS, 32, address width
- INDEX_BITS, 8, set index width
- MSG_BITS, 4, message code width
- MAX_OFFSET_BITS, 3, system-wide maximum offset bits; informational only
- REQ_BUF_DEPTH_BITS, 2, log2 depth of the forwarded-request FIFO
- RESP_BUF_DEPTH_BITS, 2, log2 depth of the response FIFO
- CORE, 0 and CACHE_NO, 0, identification only
- CONTROLLER_TYPE, "BLOCKING", the only supported value
- ID_BITS, 2, NoC node ID width
- DEFAULT_DEST, 0, directory node ID
- Derived parameters:
  - CACHE_WORDS = 2^CACHE_OFFSET_BITS
  - CACHE_WIDTH = DATA_WIDTH*CACHE_WORDS
  - WAY_BITS = log2(ways), minimum 1
  - TAG_BITS = ADDRESS_BITS-INDEX_BITS-CACHE_OFFSET_BITS
  - SBITS = COHERENCE_BITS+STATUS_BITS
- Ports:
  - clock in 1; single clock
  - reset in 1; asynchronous, active-high
  - noc_msg_in, noc_address_in, noc_data_in, noc_src_id in MSG/ADDRESS/CACHE_WIDTH/ID_BITS; incoming NoC message, valid when msg≠NoMsg
  - packetizer_busy in 1; outbound NoC not ready
  - noc_msg_out, noc_address_out, noc_data_out, noc_dest_id out; outbound message
  - cache_msg_in, cache_address_in, cache_data_in in; controller request
  - cache_msg_out, cache_address_out, cache_data_out out; response to controller
  - busy out 1; either FIFO full
  - port1_read_data in CACHE_WIDTH; snoop read data
  - port1_matched_way in WAY_BITS; snoop matched way
  - port1_coh_bits in COHERENCE_BITS; snoop coherence state
  - port1_status_bits in STATUS_BITS; snoop status bits
  - port1_hit in 1; snoop hit
  - port1_read, port1_write, port1_invalidate out 1; snoop commands
  - port1_index out INDEX_BITS; snoop set index
  - port1_tag out TAG_BITS; snoop tag
  - port1_metadata out SBITS; new line metadata, packed {status, coh}
  - port1_write_data out CACHE_WIDTH; write data
  - port1_way_select out WAY_BITS; target way

## Operation
- Address split: tag = addr[ADDRESS_BITS-1 -: TAG_BITS], index = next INDEX_BITS, offset = low CACHE_OFFSET_BITS. Example: 0x2000 gives tag 0x8, index 0.
- Incoming NoC messages:
  - Inv, FwdGetS and FwdGetM are pushed to the request FIFO with their src_id.
  - DataS, DataE, DataM, PutAck and InvAck are pushed to the response FIFO.
  - Any message arriving while its FIFO is full is dropped; senders honor busy.
- Controller requests (blocking): a request other than NO_REQ with none outstanding is latched once and sent to DEFAULT_DEST.
  - R_REQ sends GetS.
  - W_REQ sends GetM.
  - WB_REQ sends PutM with cache_data_in.
  - FLUSH_REQ sends PutM with cache_data_in.
- Responses are popped in order and mapped onto cache_msg_out with address and data:
  - DataS → MEM_RESP_S
  - DataE → MEM_RESP_E
  - DataM → MEM_RESP
  - PutAck → MEM_RESP
  - A response is shown for at least 1 cycle and held while cache_msg_in≠NO_REQ.
  - When cache_msg_in returns to NO_REQ, the outstanding request clears and the next response may pop.
- Snoop FSM: IDLE → READ → WAIT → ACT → SEND → IDLE.
  - READ: pop the head of the request FIFO and assert port1_read with index and tag.
  - WAIT: capture hit, way, state and data.
  - ACT: perform the action below with way_select = matched way.
  - SEND: queue the reply to the message's src_id.
- Snoop actions, by message and line state:
  - Inv on M: invalidate; reply RespPutM with line data.
  - Inv on S or E: invalidate; reply InvAck, data 0.
  - Inv on a miss: no memory op; reply InvAck.
  - FwdGetS on E: write metadata {status unchanged, SHARED}; reply PutE, data 0.
  - FwdGetS on M: write {2'b10, SHARED}; reply RespPutM with data.
  - FwdGetS on S or miss: reply InvAck.
  - FwdGetM: handled as Inv.
- Outbound arbitration: a snoop reply has priority over a controller request.
- Outbound handshake: the message is held stable until a rising edge with packetizer_busy=0, then it is consumed. NoMsg is driven when nothing is pending.
- busy = request FIFO full OR response FIFO full.

## Timing
- Reset: all outputs 0 (NoMsg/NO_REQ), FIFOs empty, FSM IDLE, no outstanding request.
- Snoop timeline:
  - Cycle N: port1_read.
  - Cycle N+1: memory returns hit and data; read latency is 1 cycle.
  - Cycle N+2: port1_invalidate or port1_write, for one cycle.
  - Cycle N+3: reply on the NoC if packetizer_busy=0; otherwise held until it is 0.
- Next snoop READ occurs at the earliest in the cycle after the reply is consumed.
- Controller request appears on the NoC the cycle after it is latched, if not blocked.
- FIFO push and pop in the same cycle are allowed, including when full.
- port1 outputs are 0 outside their active cycle.

## Structure
- Shared package holds:
  - Message codes, 4 bits: NoMsg/NO_REQ=0, GetS/R_REQ=1, GetM/W_REQ=2, PutM/WB_REQ=3, FLUSH_REQ=4, PutE=5, Inv=6, FwdGetS=7, FwdGetM=8, DataS=9, DataE=10, DataM=11, InvAck=12, PutAck=13, RespPutM=14.
  - Controller response codes: MEM_RESP=1, MEM_RESP_S=2, MEM_RESP_E=3.
  - Coherence states: INVALID=00, EXCLUSIVE=01, MODIFIED=10, SHARED=11.
- One reusable sub-module, fifo, instantiated twice: the request FIFO and the response FIFO.

## Test plan
- R_REQ @0x1000 → GetS 0x1000 dest 0; inject DataS 0x1000 data 0x1_2_3_4 (words 1,2,3,4) → MEM_RESP_S; drop request → NoMsg.
- Inv 0x2000, snoop hit M, way 3, data 0x2000000x → invalidate tag 0x8 way 3 at N+2; RespPutM 0x2000 with data at N+3.
- Inv 0x3000, S hit way 2 → invalidate tag 0xC; InvAck, data 0. FwdGetS 0x4000, E way 0 → write metadata 4'b1011; PutE.
- Inv 0x9000 miss → no write or invalidate; InvAck at N+3. Burst of 9 back-to-back messages → none lost, busy set when a FIFO is full.
- packetizer_busy high while WB_REQ 0x20000 is pending → PutM held stable; sent after the busy toggles; PutAck → MEM_RESP 0x20000.
